// File: rtl/gpio_arbiter.sv
// Round-robin arbiter sharing one GPIO register-bus slave between two requesters.
// Supports plain read/write and atomic read-modify-write set-bits / clear-bits.
module gpio_arbiter #(
  parameter int DW = 32,
  parameter int AW = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [1:0]      req,
  input  logic [3:0]      op,
  input  logic [2*AW-1:0] addr,
  input  logic [2*DW-1:0] wdata,
  output logic [1:0]      gnt,
  output logic [1:0]      done,
  output logic [DW-1:0]   rdata,
  output logic            m_wr_en,
  output logic            m_rd_en,
  output logic [AW-1:0]   m_addr,
  output logic [DW-1:0]   m_wr_data,
  input  logic [DW-1:0]   m_rd_data
);

  localparam logic [1:0] OP_READ  = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_SET   = 2'b10;

  typedef enum logic [1:0] {IDLE, EXEC, WB} state_t;

  state_t          state, state_next;
  logic            owner;
  logic [1:0]      op_q;
  logic [AW-1:0]   addr_q;
  logic [DW-1:0]   mask_q;
  logic [DW-1:0]   old_q;
  logic            rr_last;
  logic            accept;
  logic            winner;

  // On a tie the requester that did not win last time gets the slot.
  always_comb begin
    accept = |req;
    if (req == 2'b11) winner = ~rr_last;
    else              winner = req[1];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    m_wr_en    = 1'b0;
    m_rd_en    = 1'b0;
    m_addr     = '0;
    m_wr_data  = '0;
    unique case (state)
      IDLE: begin
        if (accept) state_next = EXEC;
      end
      EXEC: begin
        m_addr = addr_q;
        if (op_q == OP_WRITE) begin
          m_wr_en    = 1'b1;
          m_wr_data  = mask_q;
          state_next = IDLE;
        end else begin
          m_rd_en    = 1'b1;
          state_next = (op_q == OP_READ) ? IDLE : WB;
        end
      end
      WB: begin
        m_wr_en    = 1'b1;
        m_addr     = addr_q;
        m_wr_data  = (op_q == OP_SET) ? (old_q | mask_q) : (old_q & ~mask_q);
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      gnt     <= 2'b00;
      done    <= 2'b00;
      rdata   <= '0;
      rr_last <= 1'b1;
      owner   <= 1'b0;
      op_q    <= OP_READ;
      addr_q  <= '0;
      mask_q  <= '0;
      old_q   <= '0;
    end else begin
      gnt  <= 2'b00;
      done <= 2'b00;
      unique case (state)
        IDLE: begin
          if (accept) begin
            owner   <= winner;
            rr_last <= winner;
            op_q    <= winner ? op[3:2] : op[1:0];
            addr_q  <= winner ? addr[2*AW-1:AW] : addr[AW-1:0];
            mask_q  <= winner ? wdata[2*DW-1:DW] : wdata[DW-1:0];
            gnt     <= winner ? 2'b10 : 2'b01;
          end
        end
        EXEC: begin
          if (op_q == OP_WRITE) begin
            rdata <= '0;
            done  <= owner ? 2'b10 : 2'b01;
          end else if (op_q == OP_READ) begin
            rdata <= m_rd_data;
            done  <= owner ? 2'b10 : 2'b01;
          end else begin
            // RMW reports the pre-modify value.
            rdata <= m_rd_data;
            old_q <= m_rd_data;
          end
        end
        WB: begin
          done <= owner ? 2'b10 : 2'b01;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_gpio_arbiter.sv
// Bench for gpio_arbiter: GPIO slave model plus scoreboard of expected completions.
module tb_gpio_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  req;
  logic [3:0]  op;
  logic [7:0]  addr;
  logic [63:0] wdata;
  logic [1:0]  gnt;
  logic [1:0]  done;
  logic [31:0] rdata;
  logic        m_wr_en;
  logic        m_rd_en;
  logic [3:0]  m_addr;
  logic [31:0] m_wr_data;
  logic [31:0] m_rd_data;

  logic [31:0] reg_data = 32'h0;
  logic [31:0] reg_dir  = 32'h0;
  logic [31:0] gpio_in  = 32'h0;
  logic [35:0] wr_log[$];

  typedef struct {
    int          who;
    logic [31:0] data;
  } exp_t;
  exp_t sb[$];

  int checks = 0;
  int errors = 0;

  gpio_arbiter #(.DW(32), .AW(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .op        (op),
    .addr      (addr),
    .wdata     (wdata),
    .gnt       (gnt),
    .done      (done),
    .rdata     (rdata),
    .m_wr_en   (m_wr_en),
    .m_rd_en   (m_rd_en),
    .m_addr    (m_addr),
    .m_wr_data (m_wr_data),
    .m_rd_data (m_rd_data)
  );

  always #5 clk = ~clk;

  always_comb begin
    m_rd_data = 32'h0;
    if (m_rd_en) begin
      case (m_addr)
        4'h0:    m_rd_data = reg_data;
        4'h4:    m_rd_data = reg_dir;
        4'h8:    m_rd_data = gpio_in;
        default: m_rd_data = 32'h0;
      endcase
    end
  end

  always @(posedge clk) begin
    if (m_wr_en === 1'b1) begin
      wr_log.push_back({m_addr, m_wr_data});
      if (m_addr == 4'h0) reg_data <= m_wr_data;
      if (m_addr == 4'h4) reg_dir  <= m_wr_data;
    end
  end

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Completion monitor: every done pulse must match the head of the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n === 1'b1) begin
      if (gnt != 2'b00) check_val("gnt_onehot", 64'($countones(gnt)), 64'd1);
      if (done != 2'b00) begin
        check_val("done_onehot", 64'($countones(done)), 64'd1);
        if (sb.size() == 0) begin
          check_val("unexpected_done", {62'd0, done}, 64'd0);
        end else begin
          e = sb.pop_front();
          check_val("done_who", {62'd0, done}, (e.who == 0) ? 64'd1 : 64'd2);
          check_val("rdata", {32'd0, rdata}, {32'd0, e.data});
          $display("done req%0d rdata %08h", e.who, rdata);
        end
      end
    end
  end

  task automatic check_idle_outputs(input string tag);
    check_val(tag, {22'd0, gnt, done, m_wr_en, m_rd_en, m_addr, m_wr_data}, 64'd0);
    check_val({tag, "_rdata"}, {32'd0, rdata}, 64'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req   = 2'b00;
    @(negedge clk);
    @(negedge clk);
    check_idle_outputs("reset_outs");
    rst_n = 1'b1;
  endtask

  task automatic single(input int i, input logic [1:0] o, input logic [3:0] a,
                        input logic [31:0] d, input logic [31:0] exp_r, input int lat);
    int n;
    bit got_done;
    sb.push_back('{i, exp_r});
    @(negedge clk);
    req[i]            = 1'b1;
    op[2*i +: 2]      = o;
    addr[4*i +: 4]    = a;
    wdata[32*i +: 32] = d;
    n = 0;
    got_done = 1'b0;
    while (!got_done && n < 20) begin
      @(negedge clk);
      n++;
      if (gnt[i]) begin
        check_val("gnt_lat", 64'(n), 64'd1);
        check_val("exec_rd_en", {63'd0, m_rd_en}, {63'd0, o != 2'b01});
        check_val("exec_wr_en", {63'd0, m_wr_en}, {63'd0, o == 2'b01});
        req[i] = 1'b0;
      end
      if (done[i]) begin
        got_done = 1'b1;
        check_val("done_lat", 64'(n), 64'(lat));
      end
    end
    if (!got_done) check_val("done_timeout", 64'd0, 64'd1);
  endtask

  task automatic both_req(input logic [3:0] o, input logic [7:0] a, input logic [63:0] d,
                          input logic [1:0] first);
    int n;
    int ng;
    @(negedge clk);
    req   = 2'b11;
    op    = o;
    addr  = a;
    wdata = d;
    n  = 0;
    ng = 0;
    while ((req != 2'b00 || sb.size() != 0) && n < 30) begin
      @(negedge clk);
      n++;
      if (gnt != 2'b00) begin
        if (ng == 0) check_val("first_gnt", {62'd0, gnt}, {62'd0, first});
        ng++;
        req = req & ~gnt;
      end
    end
    if (sb.size() != 0) check_val("both_timeout", 64'(sb.size()), 64'd0);
    req = 2'b00;
  endtask

  initial begin
    int n;
    int ng;
    logic [1:0] exp_g;
    rst_n = 1'b0;
    req   = 2'b00;
    op    = 4'h0;
    addr  = 8'h0;
    wdata = 64'h0;

    do_reset();

    // Plain write then read-back of the direction register.
    wr_log.delete();
    single(0, 2'b01, 4'h4, 32'h0000_00FF, 32'h0, 2);
    check_val("wr_log_n", 64'(wr_log.size()), 64'd1);
    check_val("wr_log_dir", {28'd0, wr_log[0]}, {28'd0, 4'h4, 32'h0000_00FF});
    single(0, 2'b00, 4'h4, 32'h0, 32'h0000_00FF, 2);

    // Both requesters writing continuously: grants alternate, requester 0 first.
    do_reset();
    for (int k = 0; k < 4; k++) sb.push_back('{k % 2, 32'h0});
    @(negedge clk);
    req   = 2'b11;
    op    = 4'b0101;
    addr  = 8'h00;
    wdata = {32'h22, 32'h11};
    n = 0;
    ng = 0;
    exp_g = 2'b01;
    while ((ng < 4 || sb.size() != 0) && n < 40) begin
      @(negedge clk);
      n++;
      if (gnt != 2'b00) begin
        check_val("alt_gnt", {62'd0, gnt}, {62'd0, exp_g});
        $display("grant %b", gnt);
        exp_g = ~exp_g;
        ng++;
        if (ng == 4) req = 2'b00;
      end
    end
    check_val("alt_count", 64'(ng), 64'd4);
    req = 2'b00;

    // RMW set-bits from requester 1.
    single(0, 2'b01, 4'h0, 32'h0000_00F0, 32'h0, 2);
    wr_log.delete();
    single(1, 2'b10, 4'h0, 32'h0000_000F, 32'h0000_00F0, 3);
    check_val("set_log_n", 64'(wr_log.size()), 64'd1);
    check_val("set_wdata", {28'd0, wr_log[0]}, {28'd0, 4'h0, 32'h0000_00FF});
    check_val("set_reg", {32'd0, reg_data}, 64'h0000_00FF);

    // Clear-bits RMW contending with a plain write: RMW must stay atomic.
    wr_log.delete();
    sb.push_back('{0, 32'h0000_00FF});
    sb.push_back('{1, 32'h0});
    both_req({2'b01, 2'b11}, 8'h00, {32'h0000_1234, 32'h0000_000F}, 2'b01);
    check_val("cont_log_n", 64'(wr_log.size()), 64'd2);
    check_val("cont_wb", {28'd0, wr_log[0]}, {28'd0, 4'h0, 32'h0000_00F0});
    check_val("cont_wr", {28'd0, wr_log[1]}, {28'd0, 4'h0, 32'h0000_1234});
    check_val("cont_reg", {32'd0, reg_data}, 64'h0000_1234);

    // Reset during the read phase of a set-bits: no write-back, no done.
    wr_log.delete();
    @(negedge clk);
    req[0]      = 1'b1;
    op[1:0]     = 2'b10;
    addr[3:0]   = 4'h0;
    wdata[31:0] = 32'h0000_0F00;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!gnt[0] && n < 10);
    check_val("rmw_gnt", {63'd0, gnt[0]}, 64'd1);
    check_val("rmw_rd_en", {63'd0, m_rd_en}, 64'd1);
    rst_n = 1'b0;
    req   = 2'b00;
    @(negedge clk);
    check_idle_outputs("midrst_outs");
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check_val("midrst_no_wr", 64'(wr_log.size()), 64'd0);
    check_val("midrst_reg", {32'd0, reg_data}, 64'h0000_1234);

    // Tie right after reset goes to requester 0; input pins and unmapped read.
    gpio_in = 32'hA5A5_A5A5;
    sb.push_back('{0, 32'hA5A5_A5A5});
    sb.push_back('{1, 32'h0});
    both_req(4'b0000, {4'hC, 4'h8}, 64'h0, 2'b01);

    repeat (3) @(negedge clk);
    check_val("sb_empty", 64'(sb.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
